sine_period_detector: RTL
=========================

// Module: sine_period_detector
// PURPOSE
//  Receive-side monitor for the sine generator's 16-bit sample stream.
//  Finds rising midscale crossings with hysteresis and counts valid samples per cycle.
//  Reports the period, lock status and a stall timeout.
//  Sits between the sample source and the display/readout logic.
// PARAMETERS
//  DATA_W      16       sample width; samples are unsigned, offset binary
//  CNT_W       11       period counter width; matches 1024-entry LUT + margin
//  MIDSCALE    16'h8000 crossing threshold (zero level)
//  HYST        16'h0100 hysteresis half-band; must be < MIDSCALE
//  MAX_PERIOD  2047     sample count that triggers timeout; <= 2**CNT_W-1
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       asynchronous, active-high reset
//  sample_in     in   DATA_W  sample; used only when sample_valid=1
//  sample_valid  in   1       qualifies sample_in; may be held low any number of cycles
//  period_out    out  CNT_W   last measured period, in valid samples
//  period_valid  out  1       1-cycle pulse when period_out updates
//  locked        out  1       two consecutive equal periods measured
//  timeout       out  1       no rising crossing within MAX_PERIOD samples
//  peak_out      out  DATA_W  max sample of last period (PEAK_TRACK_EN)
//  trough_out    out  DATA_W  min sample of last period (PEAK_TRACK_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; level state UNK; counter 0; armed=0.
//  - Level FSM advances only on sample_valid. Thresholds LO=MIDSCALE-HYST and HI=MIDSCALE+HYST are fixed at elaboration.
//    - UNK: sample<LO -> LOW; sample>=HI -> HIGH; otherwise stay UNK.
//    - LOW: sample>=HI -> HIGH; this is a rising crossing.
//    - HIGH: sample<LO -> LOW.
//    - Samples in [LO,HI) never change state.
//  - Counter, per valid sample:
//    - Non-crossing sample: cnt <= cnt+1, saturating at MAX_PERIOD.
//    - Crossing sample: cnt <= 0.
//  - On a crossing with armed=1:
//    - period_out <= cnt+1 and period_valid=1 in the next cycle. Latency is 1 clk after the crossing sample.
//    - locked <= (cnt+1 == previous period_out) and a previous period exists.
//  - On a crossing with armed=0: armed <= 1; no period_valid pulse.
//  - Any crossing clears timeout.
//  - cnt reaching MAX_PERIOD (non-crossing sample):
//    - timeout <= 1, locked <= 0, armed <= 0; the previous-period history is discarded.
//    - period_out holds its last value.
//  - A crossing on the same sample that would saturate the counter counts as a crossing; the crossing wins.
//  - sample_valid=0: no state, counter or output change; period_valid=0.
//  - rst mid-measurement: immediate return to reset values; the partial period is discarded.
// CONFIGURATION
//  PEAK_TRACK_EN defined:
//    - Running max/min are updated on every valid sample.
//    - On a crossing with armed=1: peak_out/trough_out <= max/min of samples since the previous crossing, including the current one. Both update with period_valid.
//    - Running max/min reload from the crossing sample.
//    - Timeout re-seeds the trackers.
//  PEAK_TRACK_EN undefined: peak_out=trough_out=0 constantly; no tracker logic is built.
// TESTING
//  1 Square wave, valid every clk: 10x0000,10xFFFF repeated -> pulse with period_out=20 at the 2nd rising crossing; locked=1 at the 3rd.
//  2 Noise 0x7F80..0x807F after an established LOW state -> no crossing, no pulse; cnt keeps counting.
//  3 Test 1 stream with sample_valid toggling every clk -> period_out=20 (sample count, not clocks); pulse is 1 clk wide.
//  4 Hold 0x0000 for 2047 valid samples -> timeout=1, locked=0; resume test 1 -> timeout clears at the first crossing, period_valid at the second.
//  5 Assert rst for 1 clk mid-period, then resume test 1 -> all outputs 0 on the rst edge; the first pulse comes only after two new crossings.
//  6 PEAK_TRACK_EN, full 1024-sample sine LUT spanning 0000..FFFF -> period_out=1024, peak_out=FFFF, trough_out=0000; without the macro both read 0.

Source files
------------

// File: rtl/sine_period_detector.sv
// Receive-side period monitor for an unsigned, offset-binary sine sample stream.
// Detects rising midscale crossings with hysteresis, counts valid samples per
// cycle and reports period, lock and stall timeout.
// Optional build macro: PEAK_TRACK_EN adds per-period max/min sample tracking;
// without it peak_out/trough_out are tied to zero.
module sine_period_detector #(
   parameter int unsigned        DATA_W     = 16,
   parameter int unsigned        CNT_W      = 11,
   parameter logic [DATA_W-1:0]  MIDSCALE   = 16'h8000,
   parameter logic [DATA_W-1:0]  HYST       = 16'h0100,
   parameter int unsigned        MAX_PERIOD = 2047
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   output logic [CNT_W-1:0]  period_out,
   output logic              period_valid,
   output logic              locked,
   output logic              timeout,
   output logic [DATA_W-1:0] peak_out,
   output logic [DATA_W-1:0] trough_out
);

   localparam logic [DATA_W-1:0] LO       = MIDSCALE - HYST;
   localparam logic [DATA_W-1:0] HI       = MIDSCALE + HYST;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(MAX_PERIOD - 1);

   typedef enum logic [1:0] {StUnk, StLow, StHigh} level_e;

   level_e             r_level;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_armed;
   logic               r_has_prev;

   logic               w_below;
   logic               w_above;
   logic               w_cross;
   logic               w_reach;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_below   = (sample_in < LO);
   assign w_above   = (sample_in >= HI);
   // Only a LOW -> HIGH transition is a rising crossing; UNK -> HIGH is not.
   assign w_cross   = sample_valid && (r_level == StLow) && w_above;
   // Non-crossing sample that brings (or keeps) the counter at saturation.
   assign w_reach   = sample_valid && !w_cross && (r_cnt >= CNT_PRE);
   assign w_cnt_inc = r_cnt + 1'b1;

   // Level FSM, sample counter and period/lock/timeout reporting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_level      <= StUnk;
         r_cnt        <= '0;
         r_armed      <= 1'b0;
         r_has_prev   <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (sample_valid) begin
            case (r_level)
               StUnk: begin
                  if (w_below) begin
                     r_level <= StLow;
                  end else if (w_above) begin
                     r_level <= StHigh;
                  end
               end
               StLow: begin
                  if (w_above) begin
                     r_level <= StHigh;
                  end
               end
               StHigh: begin
                  if (w_below) begin
                     r_level <= StLow;
                  end
               end
               default: r_level <= StUnk;
            endcase

            if (w_cross) begin
               // Crossing wins over saturation on the same sample.
               r_cnt   <= '0;
               timeout <= 1'b0;
               if (r_armed) begin
                  period_out   <= w_cnt_inc;
                  period_valid <= 1'b1;
                  locked       <= r_has_prev && (w_cnt_inc == period_out);
                  r_has_prev   <= 1'b1;
               end else begin
                  r_armed <= 1'b1;
               end
            end else if (w_reach) begin
               // Stall: drop lock and history; period_out keeps the last value.
               r_cnt      <= CNT_MAX;
               timeout    <= 1'b1;
               locked     <= 1'b0;
               r_armed    <= 1'b0;
               r_has_prev <= 1'b0;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

`ifdef PEAK_TRACK_EN
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic [DATA_W-1:0] w_max_nxt;
   logic [DATA_W-1:0] w_min_nxt;

   assign w_max_nxt = (sample_in > r_max) ? sample_in : r_max;
   assign w_min_nxt = (sample_in < r_min) ? sample_in : r_min;

   // Running max/min since the last crossing; published alongside period_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_max      <= '0;
         r_min      <= '1;
         peak_out   <= '0;
         trough_out <= '0;
      end else if (sample_valid) begin
         if (w_cross) begin
            if (r_armed) begin
               peak_out   <= w_max_nxt;
               trough_out <= w_min_nxt;
            end
            r_max <= sample_in;
            r_min <= sample_in;
         end else if (w_reach) begin
            r_max <= sample_in;
            r_min <= sample_in;
         end else begin
            r_max <= w_max_nxt;
            r_min <= w_min_nxt;
         end
      end
   end
`else
   assign peak_out   = '0;
   assign trough_out = '0;
`endif

endmodule
